approx_mult_pipe: RTL and testbench

Parametrised, pipelined unsigned WIDTH×WIDTH multiplier built from a grid of 4×4 tile products. Each tile can run exact or approximate per transaction. A valid/ready handshake on both sides provides back-pressure. It is the streaming successor to the fixed-width combinational 8×8 tile multipliers and sits in the datapath wherever a registered, throttleable approximate product is needed.

---
 rtl/approx_mult_pipe.sv | 145 ++++++++++++++
 tb/tb_approx_mult_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pipe
// Purpose  : Pipelined unsigned WIDTH x WIDTH multiplier assembled from a grid
//            of 4x4 nibble tile products. Each tile is exact or approximate
//            (low TRUNC bits of the tile product cleared) per beat. Elastic
//            three-stage pipeline with valid/ready on both sides.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - operand beat offered
//            in_ready   - beat can be accepted this cycle
//            in_a/in_b  - unsigned operands, WIDTH bits
//            in_mode    - per-tile approximate select, NT bits
//            out_valid  - result beat present
//            out_ready  - downstream accepts result
//            out_r      - product, 2*WIDTH bits
//            out_exact  - beat was issued with in_mode all zeros
//            occupancy  - number of valid pipeline stages (0..3)
// Revision : 1.0 - initial release
// ============================================================================
module approx_mult_pipe #(
  parameter  int WIDTH = 8,
  parameter  int TRUNC = 2,
  localparam int NA    = WIDTH / 4,
  localparam int NT    = NA * NA
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [NT-1:0]      in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r,
  output logic               out_exact,
  output logic [1:0]         occupancy
);

  // Keeps bits [7:TRUNC] of an approximate tile product.
  localparam logic [7:0] c_trunc_mask = 8'hFF << TRUNC;

  // Stage 1: captured operands
  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [NT-1:0]      r_s1_mode;
  logic               r_s1_exact;

  // Stage 2: tile products (tile shifts are fixed by tile position)
  logic               r_s2_valid;
  logic [NT-1:0][7:0] r_s2_prod;
  logic               r_s2_exact;

  // Stage 3: summed result
  logic               r_s3_valid;
  logic [2*WIDTH-1:0] r_s3_r;
  logic               r_s3_exact;

  logic               w_s3_fire;
  logic               w_s3_load;
  logic               w_s2_load;
  logic               w_s1_load;
  logic [NT-1:0][7:0] w_prod;
  logic [2*WIDTH-1:0] w_sum;

  // Ready ripples backwards from out_ready; in_valid never feeds in_ready.
  assign w_s3_fire = r_s3_valid & out_ready;
  assign w_s3_load = r_s2_valid & (~r_s3_valid | w_s3_fire);
  assign w_s2_load = r_s1_valid & (~r_s2_valid | w_s3_load);
  assign in_ready  = ~r_s1_valid | w_s2_load;
  assign w_s1_load = in_valid & in_ready;

  // Tile t = i*NA + j pairs nibble i of A with nibble j of B.
  for (genvar gi = 0; gi < NA; gi++) begin : g_row
    for (genvar gj = 0; gj < NA; gj++) begin : g_col
      localparam int c_t = gi * NA + gj;
      logic [7:0] w_full;
      assign w_full    = {4'b0000, r_s1_a[4*gi +: 4]} * {4'b0000, r_s1_b[4*gj +: 4]};
      assign w_prod[c_t] = r_s1_mode[c_t] ? (w_full & c_trunc_mask) : w_full;
    end
  end

  // Weighted sum of the tile products; tile t sits at 4*(i+j).
  always_comb begin
    w_sum = '0;
    for (int t = 0; t < NT; t++) begin
      w_sum = w_sum + ({{(2*WIDTH-8){1'b0}}, r_s2_prod[t]} << (4 * ((t / NA) + (t % NA))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
      r_s1_exact <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_mode  <= in_mode;
      r_s1_exact <= (in_mode == '0);
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_exact <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s2_prod  <= w_prod;
      r_s2_exact <= r_s1_exact;
    end else if (w_s3_load) begin
      r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_r     <= '0;
      r_s3_exact <= 1'b0;
    end else if (w_s3_load) begin
      r_s3_valid <= 1'b1;
      r_s3_r     <= w_sum;
      r_s3_exact <= r_s2_exact;
    end else if (w_s3_fire) begin
      r_s3_valid <= 1'b0;
    end
  end

  assign out_valid = r_s3_valid;
  assign out_r     = r_s3_r;
  assign out_exact = r_s3_exact;
  assign occupancy = {1'b0, r_s1_valid} + {1'b0, r_s2_valid} + {1'b0, r_s3_valid};

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mult_pipe
// Purpose  : Self-checking bench for approx_mult_pipe. An 8-bit instance is
//            driven through directed steps with a scoreboard queue; a 16-bit
//            instance checks the wide all-approximate corner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic        out_exact;
  logic [1:0]  occupancy;

  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_in_a;
  logic [15:0] h_in_b;
  logic [15:0] h_in_mode;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [31:0] h_out_r;
  logic        h_out_exact;
  logic [1:0]  h_occupancy;

  approx_mult_pipe #(.WIDTH(8), .TRUNC(2)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_exact (out_exact),
    .occupancy (occupancy)
  );

  approx_mult_pipe #(.WIDTH(16), .TRUNC(3)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .in_a      (h_in_a),
    .in_b      (h_in_b),
    .in_mode   (h_in_mode),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .out_r     (h_out_r),
    .out_exact (h_out_exact),
    .occupancy (h_occupancy)
  );

  int          total = 0;
  int          bad   = 0;
  int          n_in  = 0;
  int          n_out = 0;
  logic        last_acc = 1'b0;
  logic [16:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Exact product minus the bits lost by each approximate tile.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] m);
    int p;
    int ai;
    int bj;
    p = int'(a) * int'(b);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (m[i*2+j]) begin
          ai = int'((a >> (4*i)) & 8'h0F);
          bj = int'((b >> (4*j)) & 8'h0F);
          p  = p - (((ai * bj) % 4) << (4 * (i + j)));
        end
      end
    end
    return {(m == 4'd0), p[15:0]};
  endfunction

  // One clock cycle: inputs were set after the previous falling edge; observe
  // the handshakes that the coming rising edge will perform.
  task automatic step();
    logic [16:0] e;
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_r", 32'(out_r), 32'(e[15:0]));
        chk("sb_exact", 32'(out_exact), 32'(e[16]));
      end
    end
    if (last_acc) begin
      n_in++;
      sb.push_back(model(in_a, in_b, in_mode));
    end
    @(negedge clk);
  endtask

  task automatic send_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] m, input logic [15:0] er, input logic ee);
    int lat;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk({tag, "_accept"}, 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_r"}, 32'(out_r), 32'(er));
    chk({tag, "_exact"}, 32'(out_exact), 32'(ee));
    step();
  endtask

  initial begin
    int          n0;
    int          kk;
    int          lat;
    logic [15:0] hold;
    logic [31:0] exp16;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_mode     = '0;
    out_ready   = 1'b1;
    h_in_valid  = 1'b0;
    h_in_a      = '0;
    h_in_b      = '0;
    h_in_mode   = '0;
    h_out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_out_exact", 32'(out_exact), 32'd0);
    chk("rst_h_out_valid", 32'(h_out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Wide instance, every tile approximate.
    exp16 = 32'hFFFE0001;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp16 = exp16 - (32'd1 << (4 * (i + j)));
      end
    end
    h_in_a     = 16'hFFFF;
    h_in_b     = 16'hFFFF;
    h_in_mode  = 16'hFFFF;
    h_in_valid = 1'b1;
    #1;
    chk("w16_in_ready", 32'(h_in_ready), 32'd1);
    @(negedge clk);
    h_in_valid = 1'b0;
    lat = 0;
    while (!h_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("w16_valid", 32'(h_out_valid), 32'd1);
    chk("w16_r", h_out_r, exp16);
    chk("w16_exact", 32'(h_out_exact), 32'd0);
    @(negedge clk);

    // Directed single beats.
    send_one("b12x34", 8'h12, 8'h34, 4'b0000, 16'h03A8, 1'b1);
    send_one("ff_exact", 8'hFF, 8'hFF, 4'b0000, 16'hFE01, 1'b1);
    send_one("ff_approx", 8'hFF, 8'hFF, 4'b1111, 16'hFCE0, 1'b0);
    send_one("ff_tile3", 8'hFF, 8'hFF, 4'b1000, 16'hFD01, 1'b0);

    // Back-to-back stream at full rate.
    out_ready = 1'b1;
    n0 = n_out;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 8) begin
        in_valid = 1'b1;
        in_a     = 8'(k);
        in_b     = 8'(k + 1);
        in_mode  = 4'b0000;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chk("stream_count", 32'(n_out - n0), 32'd8);
    chk("stream_empty", 32'(sb.size()), 32'd0);

    // Back-pressure: fill the pipe while downstream stalls.
    out_ready = 1'b0;
    in_mode   = 4'b0101;
    n0 = n_in;
    kk = 20;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_a     = 8'(kk);
      in_b     = 8'(kk + 3);
      step();
      if (last_acc) kk++;
    end
    #1;
    chk("bp_accepted", 32'(n_in - n0), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_occupancy", 32'(occupancy), 32'd3);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    hold = out_r;
    step();
    chk("bp_out_r_stable", 32'(out_r), 32'(hold));
    chk("bp_still_3", 32'(n_in - n0), 32'd3);

    // Full pipe with downstream ready: accept and emit in the same cycle.
    out_ready = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("full_accept", 32'(last_acc), 32'd1);
    chk("full_occupancy", 32'(occupancy), 32'd3);
    in_valid = 1'b0;
    n0 = n_out;
    for (int c = 0; c < 3; c++) step();
    chk("drain_count", 32'(n_out - n0), 32'd3);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_occupancy", 32'(occupancy), 32'd0);

    // Reset while two beats are in flight.
    in_mode  = 4'b0000;
    in_valid = 1'b1;
    in_a     = 8'h33;
    in_b     = 8'h44;
    step();
    in_a = 8'h55;
    step();
    in_valid = 1'b0;
    step();
    #1;
    chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_occupancy", 32'(occupancy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_one("after_rst", 8'h0F, 8'h0F, 4'b0000, 16'h00E1, 1'b1);
    chk("after_rst_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
